// File: rtl/rs_station_if.sv
// rs_station_if: handshake and data bundle for the reservation station.
//   master : dispatch source, CDB broadcaster, flush control and FU side
//            (drives dispatch_*, cdb_*, squash, issue_ready; observes the rest)
//   slave  : the reservation station itself
//            (drives issue_*, rs_full, free_count; observes the rest)
`ifndef XLEN
`define XLEN 32
`endif

interface rs_station_if;
    logic              dispatch_valid;
    logic [2:0]        dispatch_dest_tag;
    logic [3:0]        dispatch_func;
    logic              dispatch_src1_ready;
    logic              dispatch_src2_ready;
    logic [2:0]        dispatch_src1_tag;
    logic [2:0]        dispatch_src2_tag;
    logic [`XLEN-1:0]  dispatch_src1_value;
    logic [`XLEN-1:0]  dispatch_src2_value;
    logic              cdb_valid;
    logic [2:0]        cdb_tag;
    logic [`XLEN-1:0]  cdb_value;
    logic              squash;
    logic              issue_ready;
    logic              issue_valid;
    logic [2:0]        issue_dest_tag;
    logic [3:0]        issue_func;
    logic [`XLEN-1:0]  issue_op1;
    logic [`XLEN-1:0]  issue_op2;
    logic              rs_full;
    logic [2:0]        free_count;

    modport master (
        output dispatch_valid, dispatch_dest_tag, dispatch_func,
               dispatch_src1_ready, dispatch_src2_ready,
               dispatch_src1_tag, dispatch_src2_tag,
               dispatch_src1_value, dispatch_src2_value,
               cdb_valid, cdb_tag, cdb_value, squash, issue_ready,
        input  issue_valid, issue_dest_tag, issue_func, issue_op1, issue_op2,
               rs_full, free_count
    );

    modport slave (
        input  dispatch_valid, dispatch_dest_tag, dispatch_func,
               dispatch_src1_ready, dispatch_src2_ready,
               dispatch_src1_tag, dispatch_src2_tag,
               dispatch_src1_value, dispatch_src2_value,
               cdb_valid, cdb_tag, cdb_value, squash, issue_ready,
        output issue_valid, issue_dest_tag, issue_func, issue_op1, issue_op2,
               rs_full, free_count
    );
endinterface

// File: rtl/rs_station.sv
// rs_station: 4-entry reservation station with CDB wakeup, dispatch-time
// bypass, lowest-index issue selection and a synchronous squash.
//   clock : sole clock, rising edge
//   reset : asynchronous active-high, clears every entry field
//   rs    : slave side of rs_station_if (dispatch, CDB, squash, issue,
//           rs_full, free_count)
`ifndef XLEN
`define XLEN 32
`endif

module rs_station (
    input  logic        clock,
    input  logic        reset,
    rs_station_if.slave rs
);
    localparam int ENTRIES = 4;
    localparam int XW      = `XLEN;

    logic [ENTRIES-1:0] busy_q, busy_d;
    logic [ENTRIES-1:0] rdy1_q, rdy1_d;
    logic [ENTRIES-1:0] rdy2_q, rdy2_d;
    logic [2:0]         dest_q [ENTRIES];
    logic [2:0]         dest_d [ENTRIES];
    logic [3:0]         func_q [ENTRIES];
    logic [3:0]         func_d [ENTRIES];
    logic [2:0]         tag1_q [ENTRIES];
    logic [2:0]         tag1_d [ENTRIES];
    logic [2:0]         tag2_q [ENTRIES];
    logic [2:0]         tag2_d [ENTRIES];
    logic [XW-1:0]      val1_q [ENTRIES];
    logic [XW-1:0]      val1_d [ENTRIES];
    logic [XW-1:0]      val2_q [ENTRIES];
    logic [XW-1:0]      val2_d [ENTRIES];

    logic       sel_valid;
    logic [1:0] sel_idx;
    logic       alloc_valid;
    logic [1:0] alloc_idx;
    logic [2:0] free_cnt;

    // Selection and allocation look only at registered state, so a CDB
    // capture or a freed slot becomes usable one cycle later. Scanning from
    // the top down lets the lowest index win.
    always_comb begin
        sel_valid   = 1'b0;
        sel_idx     = 2'd0;
        alloc_valid = 1'b0;
        alloc_idx   = 2'd0;
        free_cnt    = 3'd0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (busy_q[i] && rdy1_q[i] && rdy2_q[i]) begin
                sel_valid = 1'b1;
                sel_idx   = 2'(i);
            end
            if (!busy_q[i]) begin
                alloc_valid = 1'b1;
                alloc_idx   = 2'(i);
                free_cnt    = free_cnt + 3'd1;
            end
        end
    end

    assign rs.issue_valid    = sel_valid;
    assign rs.issue_dest_tag = sel_valid ? dest_q[sel_idx] : 3'd0;
    assign rs.issue_func     = sel_valid ? func_q[sel_idx] : 4'd0;
    assign rs.issue_op1      = sel_valid ? val1_q[sel_idx] : '0;
    assign rs.issue_op2      = sel_valid ? val2_q[sel_idx] : '0;
    assign rs.rs_full        = ~alloc_valid;
    assign rs.free_count     = free_cnt;

    always_comb begin
        busy_d = busy_q;
        rdy1_d = rdy1_q;
        rdy2_d = rdy2_q;
        for (int i = 0; i < ENTRIES; i++) begin
            dest_d[i] = dest_q[i];
            func_d[i] = func_q[i];
            tag1_d[i] = tag1_q[i];
            tag2_d[i] = tag2_q[i];
            val1_d[i] = val1_q[i];
            val2_d[i] = val2_q[i];
        end

        if (rs.squash) begin
            // Flush wins over capture, issue and dispatch in the same cycle.
            busy_d = '0;
        end else begin
            if (rs.cdb_valid) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    if (busy_q[i] && !rdy1_q[i] && tag1_q[i] == rs.cdb_tag) begin
                        rdy1_d[i] = 1'b1;
                        val1_d[i] = rs.cdb_value;
                    end
                    if (busy_q[i] && !rdy2_q[i] && tag2_q[i] == rs.cdb_tag) begin
                        rdy2_d[i] = 1'b1;
                        val2_d[i] = rs.cdb_value;
                    end
                end
            end

            if (sel_valid && rs.issue_ready) begin
                busy_d[sel_idx] = 1'b0;
            end

            // The allocated slot is never the issuing one (it is not busy).
            if (rs.dispatch_valid && alloc_valid) begin
                busy_d[alloc_idx] = 1'b1;
                dest_d[alloc_idx] = rs.dispatch_dest_tag;
                func_d[alloc_idx] = rs.dispatch_func;
                tag1_d[alloc_idx] = rs.dispatch_src1_tag;
                tag2_d[alloc_idx] = rs.dispatch_src2_tag;
                rdy1_d[alloc_idx] = rs.dispatch_src1_ready;
                rdy2_d[alloc_idx] = rs.dispatch_src2_ready;
                val1_d[alloc_idx] = rs.dispatch_src1_value;
                val2_d[alloc_idx] = rs.dispatch_src2_value;
                // Bypass: a producer broadcasting in the dispatch cycle would
                // otherwise be missed forever.
                if (!rs.dispatch_src1_ready && rs.cdb_valid &&
                    rs.dispatch_src1_tag == rs.cdb_tag) begin
                    rdy1_d[alloc_idx] = 1'b1;
                    val1_d[alloc_idx] = rs.cdb_value;
                end
                if (!rs.dispatch_src2_ready && rs.cdb_valid &&
                    rs.dispatch_src2_tag == rs.cdb_tag) begin
                    rdy2_d[alloc_idx] = 1'b1;
                    val2_d[alloc_idx] = rs.cdb_value;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            rdy1_q <= '0;
            rdy2_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                dest_q[i] <= '0;
                func_q[i] <= '0;
                tag1_q[i] <= '0;
                tag2_q[i] <= '0;
                val1_q[i] <= '0;
                val2_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            rdy1_q <= rdy1_d;
            rdy2_q <= rdy2_d;
            for (int i = 0; i < ENTRIES; i++) begin
                dest_q[i] <= dest_d[i];
                func_q[i] <= func_d[i];
                tag1_q[i] <= tag1_d[i];
                tag2_q[i] <= tag2_d[i];
                val1_q[i] <= val1_d[i];
                val2_q[i] <= val2_d[i];
            end
        end
    end
endmodule

// File: tb/tb_rs_station.sv
// tb_rs_station: randomized and directed bench for rs_station with an
// entry-level behavioural model and a per-cycle output compare.
`ifndef XLEN
`define XLEN 32
`endif

module tb_rs_station;
    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;

    rs_station_if rsif();

    rs_station dut (
        .clock (clock),
        .reset (reset),
        .rs    (rsif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic             busy;
        logic [2:0]       dest;
        logic [3:0]       func;
        logic             r1;
        logic             r2;
        logic [2:0]       t1;
        logic [2:0]       t2;
        logic [`XLEN-1:0] v1;
        logic [`XLEN-1:0] v2;
    } entry_t;

    entry_t m [4];

    // Lowest busy entry holding both operands, or -1.
    function automatic int pick_issue();
        for (int i = 0; i < 4; i++)
            if (m[i].busy && m[i].r1 && m[i].r2) return i;
        return -1;
    endfunction

    // Lowest idle entry, or -1 when the station is full.
    function automatic int first_free();
        for (int i = 0; i < 4; i++)
            if (!m[i].busy) return i;
        return -1;
    endfunction

    function automatic int count_free();
        int n = 0;
        for (int i = 0; i < 4; i++)
            if (!m[i].busy) n++;
        return n;
    endfunction

    // What entry i holds after the coming edge, given current inputs.
    function automatic entry_t next_entry(int i);
        entry_t e = m[i];
        int s = pick_issue();
        int f = first_free();
        if (rsif.squash) begin
            e.busy = 1'b0;
            return e;
        end
        if (e.busy && rsif.cdb_valid) begin
            if (!e.r1 && e.t1 == rsif.cdb_tag) begin e.r1 = 1'b1; e.v1 = rsif.cdb_value; end
            if (!e.r2 && e.t2 == rsif.cdb_tag) begin e.r2 = 1'b1; e.v2 = rsif.cdb_value; end
        end
        if (i == s && rsif.issue_ready) e.busy = 1'b0;
        if (i == f && rsif.dispatch_valid) begin
            e.busy = 1'b1;
            e.dest = rsif.dispatch_dest_tag;
            e.func = rsif.dispatch_func;
            e.t1   = rsif.dispatch_src1_tag;
            e.t2   = rsif.dispatch_src2_tag;
            e.r1   = rsif.dispatch_src1_ready;
            e.r2   = rsif.dispatch_src2_ready;
            e.v1   = rsif.dispatch_src1_value;
            e.v2   = rsif.dispatch_src2_value;
            if (!e.r1 && rsif.cdb_valid && e.t1 == rsif.cdb_tag) begin e.r1 = 1'b1; e.v1 = rsif.cdb_value; end
            if (!e.r2 && rsif.cdb_valid && e.t2 == rsif.cdb_tag) begin e.r2 = 1'b1; e.v2 = rsif.cdb_value; end
        end
        return e;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) m[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) m[i] <= next_entry(i);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clock) begin
        int s;
        s = pick_issue();
        check("issue_valid", 64'(rsif.issue_valid), 64'(s >= 0));
        check("issue_dest_tag", 64'(rsif.issue_dest_tag), (s >= 0) ? 64'(m[s].dest) : 64'd0);
        check("issue_func", 64'(rsif.issue_func), (s >= 0) ? 64'(m[s].func) : 64'd0);
        check("issue_op1", 64'(rsif.issue_op1), (s >= 0) ? 64'(m[s].v1) : 64'd0);
        check("issue_op2", 64'(rsif.issue_op2), (s >= 0) ? 64'(m[s].v2) : 64'd0);
        check("rs_full", 64'(rsif.rs_full), 64'(count_free() == 0));
        check("free_count", 64'(rsif.free_count), 64'(count_free()));
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        rsif.dispatch_valid = 1'b0;
        rsif.cdb_valid      = 1'b0;
        rsif.squash         = 1'b0;
    endtask

    task automatic set_dispatch(input logic [2:0] dest, input logic [3:0] func,
                                input logic r1, input logic [2:0] t1, input logic [`XLEN-1:0] v1,
                                input logic r2, input logic [2:0] t2, input logic [`XLEN-1:0] v2);
        rsif.dispatch_valid      = 1'b1;
        rsif.dispatch_dest_tag   = dest;
        rsif.dispatch_func       = func;
        rsif.dispatch_src1_ready = r1;
        rsif.dispatch_src1_tag   = t1;
        rsif.dispatch_src1_value = v1;
        rsif.dispatch_src2_ready = r2;
        rsif.dispatch_src2_tag   = t2;
        rsif.dispatch_src2_value = v2;
    endtask

    task automatic set_cdb(input logic [2:0] tag, input logic [`XLEN-1:0] val);
        rsif.cdb_valid = 1'b1;
        rsif.cdb_tag   = tag;
        rsif.cdb_value = val;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        clear_inputs();
        set_dispatch(3'd0, 4'd0, 1'b0, 3'd0, '0, 1'b0, 3'd0, '0);
        rsif.dispatch_valid = 1'b0;
        rsif.cdb_tag        = 3'd0;
        rsif.cdb_value      = '0;
        rsif.issue_ready    = 1'b0;
        #2;
        check("reset issue_valid", 64'(rsif.issue_valid), 64'd0);
        check("reset rs_full", 64'(rsif.rs_full), 64'd0);
        check("reset free_count", 64'(rsif.free_count), 64'd4);
        #10 reset = 1'b0;
        step();

        // Both operands ready: issuable the next cycle, gone the one after.
        set_dispatch(3'd5, 4'd9, 1'b1, 3'd0, 10, 1'b1, 3'd0, 20);
        rsif.issue_ready = 1'b1;
        step();
        clear_inputs();
        check("ready issue_valid", 64'(rsif.issue_valid), 64'd1);
        check("ready dest", 64'(rsif.issue_dest_tag), 64'd5);
        check("ready func", 64'(rsif.issue_func), 64'd9);
        check("ready op1", 64'(rsif.issue_op1), 64'd10);
        check("ready op2", 64'(rsif.issue_op2), 64'd20);
        step();
        check("ready freed", 64'(rsif.free_count), 64'd4);
        rsif.issue_ready = 1'b0;

        // Wakeup from the CDB, visible one cycle after the broadcast.
        set_dispatch(3'd2, 4'd1, 1'b0, 3'd3, 0, 1'b1, 3'd0, 1);
        step();
        clear_inputs();
        check("wait issue_valid", 64'(rsif.issue_valid), 64'd0);
        set_cdb(3'd3, 'h55);
        step();
        clear_inputs();
        check("wakeup issue_valid", 64'(rsif.issue_valid), 64'd1);
        check("wakeup op1", 64'(rsif.issue_op1), 64'h55);
        rsif.issue_ready = 1'b1;
        step();
        rsif.issue_ready = 1'b0;

        // Dispatch-time bypass on source 2.
        set_dispatch(3'd6, 4'd2, 1'b1, 3'd0, 9, 1'b0, 3'd4, 0);
        set_cdb(3'd4, 7);
        step();
        clear_inputs();
        check("bypass issue_valid", 64'(rsif.issue_valid), 64'd1);
        check("bypass op2", 64'(rsif.issue_op2), 64'd7);
        check("bypass op1", 64'(rsif.issue_op1), 64'd9);
        rsif.issue_ready = 1'b1;
        step();
        rsif.issue_ready = 1'b0;

        // Fill, ignore a fifth dispatch, resolve entry 2 only.
        for (int k = 0; k < 4; k++) begin
            set_dispatch(3'(k), 4'(k), 1'b0, (k == 2) ? 3'd6 : 3'd7, 0, 1'b1, 3'd0, 32'(k));
            step();
        end
        clear_inputs();
        check("full rs_full", 64'(rsif.rs_full), 64'd1);
        check("full free_count", 64'(rsif.free_count), 64'd0);
        set_dispatch(3'd7, 4'd7, 1'b1, 3'd0, 1, 1'b1, 3'd0, 2);
        step();
        clear_inputs();
        check("fifth ignored free", 64'(rsif.free_count), 64'd0);
        check("fifth ignored valid", 64'(rsif.issue_valid), 64'd0);
        set_cdb(3'd6, 'h66);
        step();
        clear_inputs();
        check("entry2 issue_valid", 64'(rsif.issue_valid), 64'd1);
        check("entry2 dest", 64'(rsif.issue_dest_tag), 64'd2);
        check("entry2 op1", 64'(rsif.issue_op1), 64'h66);
        rsif.issue_ready = 1'b1;
        step();
        rsif.issue_ready = 1'b0;
        check("after issue rs_full", 64'(rsif.rs_full), 64'd0);
        check("after issue free", 64'(rsif.free_count), 64'd1);
        rsif.squash = 1'b1;
        step();
        clear_inputs();
        check("squash free", 64'(rsif.free_count), 64'd4);

        // Back-pressure holds the lowest entry, then squash empties.
        set_dispatch(3'd3, 4'd3, 1'b1, 3'd0, 'h30, 1'b1, 3'd0, 'h31);
        step();
        set_dispatch(3'd4, 4'd4, 1'b1, 3'd0, 'h40, 1'b1, 3'd0, 'h41);
        step();
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            check("hold dest", 64'(rsif.issue_dest_tag), 64'd3);
            check("hold op1", 64'(rsif.issue_op1), 64'h30);
            step();
        end
        rsif.squash = 1'b1;
        check("pre-squash issue_valid", 64'(rsif.issue_valid), 64'd1);
        step();
        clear_inputs();
        check("post-squash issue_valid", 64'(rsif.issue_valid), 64'd0);
        check("post-squash free", 64'(rsif.free_count), 64'd4);

        // Asynchronous reset with three busy, issuable entries.
        for (int k = 1; k <= 3; k++) begin
            set_dispatch(3'(k), 4'd0, 1'b1, 3'd0, 32'(k), 1'b1, 3'd0, 32'(k));
            step();
        end
        clear_inputs();
        check("pre-reset free", 64'(rsif.free_count), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("async reset issue_valid", 64'(rsif.issue_valid), 64'd0);
        check("async reset rs_full", 64'(rsif.rs_full), 64'd0);
        check("async reset free", 64'(rsif.free_count), 64'd4);
        #3 reset = 1'b0;
        step();
        step();
        check("after reset issue_valid", 64'(rsif.issue_valid), 64'd0);

        // Randomized traffic, including one mid-run asynchronous reset.
        for (int c = 0; c < 3000; c++) begin
            rsif.dispatch_valid      = ($urandom_range(0, 9) < 6);
            rsif.dispatch_dest_tag   = 3'($urandom_range(0, 7));
            rsif.dispatch_func       = 4'($urandom_range(0, 15));
            rsif.dispatch_src1_ready = 1'($urandom_range(0, 1));
            rsif.dispatch_src2_ready = 1'($urandom_range(0, 1));
            rsif.dispatch_src1_tag   = 3'($urandom_range(0, 7));
            rsif.dispatch_src2_tag   = 3'($urandom_range(0, 7));
            rsif.dispatch_src1_value = `XLEN'($urandom());
            rsif.dispatch_src2_value = `XLEN'($urandom());
            rsif.cdb_valid           = 1'($urandom_range(0, 1));
            rsif.cdb_tag             = 3'($urandom_range(0, 7));
            rsif.cdb_value           = `XLEN'($urandom());
            rsif.squash              = ($urandom_range(0, 63) == 0);
            rsif.issue_ready         = 1'($urandom_range(0, 1));
            step();
            if (c == 1500) begin
                #2 reset = 1'b1;
                #4 reset = 1'b0;
            end
        end
        clear_inputs();
        rsif.issue_ready = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rs_station.md
RS_STATION -- requirements
Module: rs_station

Interface
REQ-001 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port dispatch_valid  input  1  new instruction presented this cycle.
REQ-004 SHALL have port dispatch_dest_tag  input  3  destination tag later broadcast on the CDB.
REQ-005 SHALL have port dispatch_func  input  4  opaque FU opcode, passed through unchanged.
REQ-006 SHALL have ports dispatch_src1_ready / dispatch_src2_ready  input  1  operand value already valid.
REQ-007 SHALL have ports dispatch_src1_tag / dispatch_src2_tag  input  3  producer tag when operand not ready.
REQ-008 SHALL have ports dispatch_src1_value / dispatch_src2_value  input  `XLEN  operand value when ready.
REQ-009 SHALL have port cdb_valid  input  1  CDB broadcast valid this cycle.
REQ-010 SHALL have port cdb_tag  input  3  broadcast tag.
REQ-011 SHALL have port cdb_value  input  `XLEN  broadcast result.
REQ-012 SHALL have port squash  input  1  synchronous flush of all entries.
REQ-013 SHALL have port issue_ready  input  1  FU accepts the issued instruction this cycle.
REQ-014 SHALL have port issue_valid  output  1  an entry with both operands ready is presented.
REQ-015 SHALL have ports issue_dest_tag (3), issue_func (4), issue_op1 (`XLEN), issue_op2 (`XLEN)  output  issued entry contents.
REQ-016 SHALL have port rs_full  output  1  all entries busy.
REQ-017 SHALL have port free_count  output  3  number of non-busy entries, 0..4.

Function
REQ-018 SHALL hold 4 entries, each: busy, dest_tag, func, per source {ready, tag, value}.
REQ-019 SHALL accept dispatch at the clock edge when dispatch_valid=1 and rs_full=0, writing the lowest-index non-busy entry and setting busy=1.
REQ-020 SHALL ignore dispatch_valid=1 while rs_full=1 (no entry modified, no error flag).
REQ-021 SHALL, when cdb_valid=1, for every busy entry and each source with ready=0 and tag==cdb_tag, store cdb_value and set ready=1 at that edge; multiple entries/sources may capture from one broadcast.
REQ-022 SHALL never alter a source already ready=1, even on tag match.
REQ-023 SHALL bypass at dispatch: if a dispatched source has ready=0, cdb_valid=1 and tag==cdb_tag in the same cycle, the entry is written with that source ready=1 and value=cdb_value.
REQ-024 SHALL drive issue_valid=1 combinationally when any busy entry has both sources ready; selected entry is the lowest such index; issue_* reflect that entry.
REQ-025 SHALL drive issue_dest_tag, issue_func, issue_op1, issue_op2 to 0 when issue_valid=0.
REQ-026 SHALL free the selected entry (busy=0) at the edge where issue_valid=1 and issue_ready=1; an entry not accepted keeps its contents and stays selected.
REQ-027 SHALL compute rs_full and free_count from registered state only; a slot freed by issue becomes dispatchable the following cycle.
REQ-028 SHALL make a source captured from the CDB visible to issue selection one cycle after capture (no same-cycle wakeup-and-issue).
REQ-029 SHALL make a dispatch with both sources ready (or bypassed) issuable the cycle after dispatch (minimum latency 1).
REQ-030 SHALL, on squash=1, clear busy in all entries at the edge; squash overrides dispatch, capture and issue in that cycle; issue_valid still reflects pre-edge state combinationally.

Reset
REQ-031 SHALL on reset clear all busy, ready, tag, value, func fields to 0, asynchronously.
REQ-032 SHALL while/after reset drive issue_valid=0, issue_* =0, rs_full=0, free_count=4.
REQ-033 SHALL, if reset asserts mid-operation, discard all pending entries; nothing issues until new dispatches occur after reset deasserts.

Verification
REQ-034 Dispatch dest=5, both ready, op1=10, op2=20, issue_ready=1 -> next cycle issue_valid=1, dest=5, op1=10, op2=20; following cycle free_count=4.
REQ-035 Dispatch dest=2, src1 not ready tag=3; later cdb_valid, tag=3, value=0x55 -> issue_valid=1 one cycle after broadcast with op1=0x55.
REQ-036 Dispatch src2 tag=4 not ready in same cycle as cdb tag=4 value=7 -> next cycle issue_valid=1, op2=7.
REQ-037 Four dispatches with unresolved sources -> rs_full=1, free_count=0; fifth dispatch ignored; broadcast resolving entry 2, issue_ready=1 -> entry 2 issues, rs_full=0 next cycle.
REQ-038 Two ready entries, issue_ready=0 for 3 cycles -> lowest-index entry held stable on issue_*; squash=1 -> next cycle issue_valid=0, free_count=4.
REQ-039 Reset asserted with 3 busy entries -> immediately issue_valid=0, rs_full=0, free_count=4.
